// File: rtl/lemming_track_ctrl.sv
// lemming_track_ctrl
// Moves one lemming along a walled 1-D track. The walker FSM reports a
// direction, and this block advances the position every TICK_DIV cycles.
// At a wall it sends the walker a one-cycle bump, then waits for the walker
// to turn and counts the completed bounce.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; outputs hold their last run values
//   RUN    | stepping the position once per TICK_DIV cycles
//   TURN   | bump issued; waiting up to 3 cycles for the walker to flip
//   DONE   | bounce limit reached; done is high for this single cycle
module lemming_track_ctrl #(
  parameter int TRACK_LEN = 16,
  parameter int POS_W     = 4,
  parameter int TICK_DIV  = 4
) (
  input  logic             i_clk,
  input  logic             i_areset_n,
  input  logic             i_start,
  input  logic [POS_W-1:0] i_start_pos,
  input  logic [7:0]       i_bounce_limit,
  input  logic             i_abort,
  input  logic             i_walk_left,
  input  logic             i_walk_right,
  output logic             o_bump_left,
  output logic             o_bump_right,
  output logic [POS_W-1:0] o_pos,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_bounce_cnt,
  output logic             o_err
);

  // A one-bit counter is kept even when TICK_DIV==1 so the compare stays legal.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(TRACK_LEN - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TURN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [POS_W-1:0]  r_pos;
  logic [TICK_W-1:0] r_tick;
  logic [7:0]        r_bounce_cnt;
  logic [7:0]        r_limit;
  logic              r_err;
  logic              r_bump_left;
  logic              r_bump_right;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_turn_cnt;
  logic              r_pre_left;

  logic [POS_W-1:0]  w_pos_nxt;
  logic [TICK_W-1:0] w_tick_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [7:0]        w_limit_nxt;
  logic              w_err_nxt;
  logic              w_bump_left_nxt;
  logic              w_bump_right_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [1:0]        w_turn_nxt;
  logic              w_pre_left_nxt;

  logic              w_step;
  logic              w_flip;
  logic              w_dir_bad;
  logic [7:0]        w_cnt_inc;
  logic [POS_W-1:0]  w_start_clamped;

  assign w_step          = (r_tick == TICK_LAST);
  assign w_dir_bad       = (i_walk_left == i_walk_right);
  // The flip only counts once the walker shows the opposite, legal direction.
  assign w_flip          = r_pre_left ? (i_walk_right & ~i_walk_left)
                                      : (i_walk_left & ~i_walk_right);
  assign w_cnt_inc       = r_bounce_cnt + 8'd1;
  assign w_start_clamped = (i_start_pos > POS_LAST) ? POS_LAST : i_start_pos;

  // State register.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode. Abort overrides everything else.
  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_tick_nxt       = r_tick;
    w_cnt_nxt        = r_bounce_cnt;
    w_limit_nxt      = r_limit;
    w_err_nxt        = r_err;
    w_bump_left_nxt  = 1'b0;
    w_bump_right_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    w_turn_nxt       = r_turn_cnt;
    w_pre_left_nxt   = r_pre_left;

    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_pos_nxt   = w_start_clamped;
            w_cnt_nxt   = 8'd0;
            w_err_nxt   = 1'b0;
            w_tick_nxt  = '0;
            w_limit_nxt = i_bounce_limit;
            w_state_nxt = S_RUN;
          end
        end

        S_RUN: begin
          // A walker claiming both or neither direction is faulty; this
          // wins over a step landing in the same cycle.
          if (w_dir_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_step) begin
            w_tick_nxt = '0;
            if (i_walk_left) begin
              if (r_pos == '0) begin
                w_bump_left_nxt = 1'b1;
                w_pre_left_nxt  = 1'b1;
                w_turn_nxt      = 2'd0;
                w_state_nxt     = S_TURN;
              end else begin
                w_pos_nxt = r_pos - POS_W'(1);
              end
            end else begin
              if (r_pos == POS_LAST) begin
                w_bump_right_nxt = 1'b1;
                w_pre_left_nxt   = 1'b0;
                w_turn_nxt       = 2'd0;
                w_state_nxt      = S_TURN;
              end else begin
                w_pos_nxt = r_pos + POS_W'(1);
              end
            end
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end

        S_TURN: begin
          if (w_flip) begin
            w_cnt_nxt  = w_cnt_inc;
            w_tick_nxt = '0;
            if ((r_limit != 8'd0) && (w_cnt_inc == r_limit)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RUN;
            end
          end else if (r_turn_cnt == 2'd2) begin
            // Third TURN cycle without a flip: the walker ignored the bump.
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_turn_nxt = r_turn_cnt + 2'd1;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_TURN);
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_pos        <= '0;
      r_tick       <= '0;
      r_bounce_cnt <= 8'd0;
      r_limit      <= 8'd0;
      r_err        <= 1'b0;
      r_bump_left  <= 1'b0;
      r_bump_right <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_turn_cnt   <= 2'd0;
      r_pre_left   <= 1'b0;
    end else begin
      r_pos        <= w_pos_nxt;
      r_tick       <= w_tick_nxt;
      r_bounce_cnt <= w_cnt_nxt;
      r_limit      <= w_limit_nxt;
      r_err        <= w_err_nxt;
      r_bump_left  <= w_bump_left_nxt;
      r_bump_right <= w_bump_right_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_turn_cnt   <= w_turn_nxt;
      r_pre_left   <= w_pre_left_nxt;
    end
  end

  assign o_pos        = r_pos;
  assign o_bounce_cnt = r_bounce_cnt;
  assign o_err        = r_err;
  assign o_bump_left  = r_bump_left;
  assign o_bump_right = r_bump_right;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
